// File: rtl/traffic_pkg.sv
`default_nettype none
// ============================================================================
// Module      : traffic_pkg
// Description : Shared state encoding, default timing constants and helpers
//               for the traffic intersection controller.
// Revision    : 1.0 - initial release
// ============================================================================
package traffic_pkg;

  // Controller states; 3-bit explicit encoding.
  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_ALL_RED     = 3'd1,
    ST_RED_YELLOW  = 3'd2,
    ST_GREEN       = 3'd3,
    ST_GREEN_BLINK = 3'd4,
    ST_YELLOW      = 3'd5
  } state_t;

  // Default timing (in 10 Hz ticks unless noted).
  localparam int c_num_phases     = 2;
  localparam int c_tw             = 8;
  localparam int c_t_red_yellow   = 10;
  localparam int c_t_min_green    = 40;
  localparam int c_t_green        = 150;
  localparam int c_t_green_blink  = 40;
  localparam int c_t_yellow       = 30;
  localparam int c_t_all_red      = 20;
  localparam int c_blink_ticks    = 5;
  localparam int c_debounce_ticks = 50;  // in 1 kHz deb_tick samples

  // States in which the blink generator runs.
  function automatic logic is_blink_state(input state_t s);
    return (s == ST_IDLE) || (s == ST_GREEN_BLINK);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ped_debounce.sv
`default_nettype none
// ============================================================================
// Module      : ped_debounce
// Description : Synchronises a raw pedestrian button, debounces it on the
//               deb_tick strobe and latches the resulting demand until it is
//               cleared by the controller.
// Revision    : 1.0 - initial release
// ============================================================================
module ped_debounce
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = c_debounce_ticks
) (
  input  logic clk,
  input  logic rst,
  input  logic i_deb_tick,
  input  logic i_ped_req,
  input  logic i_clr,
  output logic o_latched
);

  localparam int CW = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [CW-1:0] c_cnt_last = CW'(DEBOUNCE_TICKS - 1);
  localparam logic [CW-1:0] c_cnt_sat  = CW'(DEBOUNCE_TICKS);

  logic [1:0]    r_sync;
  logic [CW-1:0] r_cnt;
  logic          r_latched;
  logic          w_set;

  // The count saturates one above the trigger value so a held button latches
  // only once per press, even after the controller has cleared the demand.
  assign w_set     = i_deb_tick && r_sync[1] && (r_cnt == c_cnt_last);
  assign o_latched = r_latched;

  // Two-flop synchroniser for the asynchronous button input.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= 2'b00;
    end else begin
      r_sync <= {r_sync[0], i_ped_req};
    end
  end

  // Consecutive-sample counter and demand latch; clear has priority over set.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_latched <= 1'b0;
    end else begin
      if (i_deb_tick) begin
        if (!r_sync[1]) begin
          r_cnt <= '0;
        end else if (r_cnt != c_cnt_sat) begin
          r_cnt <= r_cnt + CW'(1);
        end
      end
      if (i_clr) begin
        r_latched <= 1'b0;
      end else if (w_set) begin
        r_latched <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/traffic_intersection_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : traffic_intersection_ctrl
// Description : Multi-phase intersection controller with fixed or actuated
//               phase rotation, pedestrian demand, emergency preemption and a
//               flashing-yellow standby mode. All lamp outputs are registered.
// Revision    : 1.0 - initial release
// ============================================================================
module traffic_intersection_ctrl
  import traffic_pkg::*;
#(
  parameter  int NUM_PHASES     = c_num_phases,
  parameter  int TW             = c_tw,
  parameter  int T_RED_YELLOW   = c_t_red_yellow,
  parameter  int T_MIN_GREEN    = c_t_min_green,
  parameter  int T_GREEN        = c_t_green,
  parameter  int T_GREEN_BLINK  = c_t_green_blink,
  parameter  int T_YELLOW       = c_t_yellow,
  parameter  int T_ALL_RED      = c_t_all_red,
  parameter  int BLINK_TICKS    = c_blink_ticks,
  parameter  int DEBOUNCE_TICKS = c_debounce_ticks,
  localparam int PW             = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tick,
  input  logic                  deb_tick,
  input  logic                  enable,
  input  logic                  actuated,
  input  logic [NUM_PHASES-1:0] car_req,
  input  logic [NUM_PHASES-1:0] ped_req,
  input  logic                  preempt,
  input  logic [PW-1:0]         preempt_phase,
  output logic [NUM_PHASES-1:0] car_red,
  output logic [NUM_PHASES-1:0] car_yellow,
  output logic [NUM_PHASES-1:0] car_green,
  output logic [NUM_PHASES-1:0] ped_red,
  output logic [NUM_PHASES-1:0] ped_green,
  output logic [NUM_PHASES-1:0] ped_latched,
  output logic [PW-1:0]         active_phase,
  output logic [TW-1:0]         remaining
);

  localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

  localparam logic [TW-1:0] c_last_ry  = TW'(T_RED_YELLOW - 1);
  localparam logic [TW-1:0] c_last_min = TW'(T_MIN_GREEN - 1);
  localparam logic [TW-1:0] c_last_g   = TW'(T_GREEN - 1);
  localparam logic [TW-1:0] c_last_gb  = TW'(T_GREEN_BLINK - 1);
  localparam logic [TW-1:0] c_last_y   = TW'(T_YELLOW - 1);
  localparam logic [TW-1:0] c_last_ar  = TW'(T_ALL_RED - 1);
  localparam logic [BW-1:0] c_blink_last = BW'(BLINK_TICKS - 1);
  localparam logic [PW-1:0] c_phase_max  = PW'(NUM_PHASES - 1);

  // Final counter value of each timed state; IDLE reports zero.
  function automatic logic [TW-1:0] f_last(input state_t s);
    case (s)
      ST_ALL_RED:     return c_last_ar;
      ST_RED_YELLOW:  return c_last_ry;
      ST_GREEN:       return c_last_g;
      ST_GREEN_BLINK: return c_last_gb;
      ST_YELLOW:      return c_last_y;
      default:        return '0;
    endcase
  endfunction

  state_t                r_state, w_state_nxt;
  logic [TW-1:0]         r_cnt, w_cnt_nxt;
  logic [PW-1:0]         r_phase, w_phase_nxt, w_phase_inc, w_phase_sel;
  logic                  r_blink, w_blink_nxt;
  logic [BW-1:0]         r_blink_cnt, w_blink_cnt_nxt;
  logic [NUM_PHASES-1:0] w_demand, w_self, w_ped_clr;
  logic                  w_preempt_valid, w_preempt_other, w_preempt_hold;
  logic                  w_other_demand, w_timer_last, w_min_done, w_found;
  logic                  w_green_entry;
  int                    w_idx;

  logic [NUM_PHASES-1:0] w_car_red, w_car_yellow, w_car_green;
  logic [NUM_PHASES-1:0] w_ped_red, w_ped_green;
  logic [TW-1:0]         w_rem_nxt;
  logic [NUM_PHASES-1:0] r_car_red, r_car_yellow, r_car_green;
  logic [NUM_PHASES-1:0] r_ped_red, r_ped_green;
  logic [TW-1:0]         r_remaining;

  // Demand from detectors and latched pedestrian calls, excluding the served phase.
  assign w_demand        = car_req | ped_latched;
  assign w_self          = NUM_PHASES'(1) << r_phase;
  assign w_other_demand  = actuated && (|(w_demand & ~w_self));
  assign w_preempt_valid = preempt && (int'(preempt_phase) < NUM_PHASES);
  assign w_preempt_other = w_preempt_valid && (preempt_phase != r_phase);
  assign w_preempt_hold  = w_preempt_valid && (preempt_phase == r_phase);
  assign w_timer_last    = (r_cnt == f_last(r_state));
  assign w_min_done      = (r_cnt >= c_last_min);

  // Phase to serve after the coming all-red: preemption, then demand search, then rotation.
  always_comb begin
    w_phase_inc = (r_phase == c_phase_max) ? '0 : r_phase + PW'(1);
    w_phase_sel = w_phase_inc;
    w_found     = 1'b0;
    w_idx       = 0;
    if (actuated) begin
      for (int k = 1; k <= NUM_PHASES; k++) begin
        w_idx = int'(r_phase) + k;
        if (w_idx >= NUM_PHASES) w_idx = w_idx - NUM_PHASES;
        if (!w_found && w_demand[w_idx]) begin
          w_found     = 1'b1;
          w_phase_sel = PW'(w_idx);
        end
      end
    end
    if (w_preempt_valid) w_phase_sel = preempt_phase;
  end

  // Next-state, tick counter and phase pointer; timed transitions only on tick.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_phase_nxt = r_phase;
    if (!enable) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = '0;
      w_phase_nxt = '0;
    end else if (tick) begin
      case (r_state)
        ST_IDLE: begin
          w_state_nxt = ST_ALL_RED;
          w_cnt_nxt   = '0;
          w_phase_nxt = '0;
        end
        ST_ALL_RED: begin
          if (w_timer_last) begin
            w_state_nxt = ST_RED_YELLOW;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + TW'(1);
          end
        end
        ST_RED_YELLOW: begin
          if (w_timer_last) begin
            w_state_nxt = ST_GREEN;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + TW'(1);
          end
        end
        ST_GREEN: begin
          if (w_preempt_other) begin
            w_state_nxt = ST_YELLOW;
            w_cnt_nxt   = '0;
          end else if (w_preempt_hold) begin
            // Hold green for the emergency vehicle; counter parks at the maximum.
            if (!w_timer_last) w_cnt_nxt = r_cnt + TW'(1);
          end else if (w_min_done && w_other_demand) begin
            w_state_nxt = ST_GREEN_BLINK;
            w_cnt_nxt   = '0;
          end else if (w_timer_last) begin
            // Actuated mode with nobody waiting rests in green.
            if (!actuated || w_other_demand) begin
              w_state_nxt = ST_GREEN_BLINK;
              w_cnt_nxt   = '0;
            end
          end else begin
            w_cnt_nxt = r_cnt + TW'(1);
          end
        end
        ST_GREEN_BLINK: begin
          if (w_preempt_other || w_timer_last) begin
            w_state_nxt = ST_YELLOW;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + TW'(1);
          end
        end
        ST_YELLOW: begin
          if (w_timer_last) begin
            w_state_nxt = ST_ALL_RED;
            w_cnt_nxt   = '0;
            w_phase_nxt = w_phase_sel;
          end else begin
            w_cnt_nxt = r_cnt + TW'(1);
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
          w_phase_nxt = '0;
        end
      endcase
    end
  end

  // Blink generator: runs while staying in a blink state, cleared whenever leaving one.
  always_comb begin
    w_blink_nxt     = r_blink;
    w_blink_cnt_nxt = r_blink_cnt;
    if (!is_blink_state(w_state_nxt)) begin
      w_blink_nxt     = 1'b0;
      w_blink_cnt_nxt = '0;
    end else if (tick && is_blink_state(r_state)) begin
      if (r_blink_cnt == c_blink_last) begin
        w_blink_nxt     = ~r_blink;
        w_blink_cnt_nxt = '0;
      end else begin
        w_blink_cnt_nxt = r_blink_cnt + BW'(1);
      end
    end
  end

  // Lamp decode from the next state so the registered lamps line up with it.
  always_comb begin
    w_car_red    = '0;
    w_car_yellow = '0;
    w_car_green  = '0;
    w_ped_red    = '0;
    w_ped_green  = '0;
    if (w_state_nxt == ST_IDLE) begin
      w_car_yellow = {NUM_PHASES{w_blink_nxt}};
    end else begin
      w_car_red = '1;
      for (int p = 0; p < NUM_PHASES; p++) begin
        if (PW'(p) == w_phase_nxt) begin
          case (w_state_nxt)
            ST_RED_YELLOW: w_car_yellow[p] = 1'b1;
            ST_GREEN: begin
              w_car_red[p]   = 1'b0;
              w_car_green[p] = 1'b1;
              w_ped_green[p] = 1'b1;
            end
            ST_GREEN_BLINK: begin
              w_car_red[p]   = 1'b0;
              w_car_green[p] = w_blink_nxt;
              w_ped_green[p] = w_blink_nxt;
            end
            ST_YELLOW: begin
              w_car_red[p]    = 1'b0;
              w_car_yellow[p] = 1'b1;
            end
            default: ;
          endcase
        end
      end
      w_ped_red = ~w_ped_green;
    end
  end

  assign w_rem_nxt = f_last(w_state_nxt) - w_cnt_nxt;

  // Controller state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_phase      <= '0;
      r_blink      <= 1'b0;
      r_blink_cnt  <= '0;
      r_car_red    <= '0;
      r_car_yellow <= '0;
      r_car_green  <= '0;
      r_ped_red    <= '0;
      r_ped_green  <= '0;
      r_remaining  <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_phase      <= w_phase_nxt;
      r_blink      <= w_blink_nxt;
      r_blink_cnt  <= w_blink_cnt_nxt;
      r_car_red    <= w_car_red;
      r_car_yellow <= w_car_yellow;
      r_car_green  <= w_car_green;
      r_ped_red    <= w_ped_red;
      r_ped_green  <= w_ped_green;
      r_remaining  <= w_rem_nxt;
    end
  end

  // A phase's pedestrian call is served when its green starts; standby drops all calls.
  assign w_green_entry = (w_state_nxt == ST_GREEN) && (r_state != ST_GREEN);

  generate
    for (genvar g = 0; g < NUM_PHASES; g++) begin : g_ped
      assign w_ped_clr[g] = !enable || (w_green_entry && (w_phase_nxt == PW'(g)));

      ped_debounce #(
        .DEBOUNCE_TICKS (DEBOUNCE_TICKS)
      ) u_ped_debounce (
        .clk        (clk),
        .rst        (rst),
        .i_deb_tick (deb_tick),
        .i_ped_req  (ped_req[g]),
        .i_clr      (w_ped_clr[g]),
        .o_latched  (ped_latched[g])
      );
    end
  endgenerate

  assign car_red      = r_car_red;
  assign car_yellow   = r_car_yellow;
  assign car_green    = r_car_green;
  assign ped_red      = r_ped_red;
  assign ped_green    = r_ped_green;
  assign active_phase = r_phase;
  assign remaining    = r_remaining;

endmodule
`default_nettype wire

// File: tb/tb_traffic_intersection_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_traffic_intersection_ctrl
// Description : Directed self-checking bench for traffic_intersection_ctrl
//               with shortened timing (3 phases, tick every cycle).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_traffic_intersection_ctrl;

  localparam int P  = 3;
  localparam int PW = 2;
  localparam int TW = 8;

  logic          clk = 1'b0;
  logic          rst, tick, deb_tick, enable, actuated, preempt;
  logic [P-1:0]  car_req, ped_req;
  logic [PW-1:0] preempt_phase;
  logic [P-1:0]  car_red, car_yellow, car_green, ped_red, ped_green, ped_latched;
  logic [PW-1:0] active_phase;
  logic [TW-1:0] remaining;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  traffic_intersection_ctrl #(
    .NUM_PHASES     (P),
    .TW             (TW),
    .T_RED_YELLOW   (2),
    .T_MIN_GREEN    (4),
    .T_GREEN        (8),
    .T_GREEN_BLINK  (4),
    .T_YELLOW       (3),
    .T_ALL_RED      (2),
    .BLINK_TICKS    (1),
    .DEBOUNCE_TICKS (3)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .tick          (tick),
    .deb_tick      (deb_tick),
    .enable        (enable),
    .actuated      (actuated),
    .car_req       (car_req),
    .ped_req       (ped_req),
    .preempt       (preempt),
    .preempt_phase (preempt_phase),
    .car_red       (car_red),
    .car_yellow    (car_yellow),
    .car_green     (car_green),
    .ped_red       (ped_red),
    .ped_green     (ped_green),
    .ped_latched   (ped_latched),
    .active_phase  (active_phase),
    .remaining     (remaining)
  );

  // Advance one clock and sample 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_lamps(input string tag, input logic [2:0] red, input logic [2:0] yel,
                           input logic [2:0] grn, input int ph, input int rem);
    chk({tag, ".red"}, 32'(car_red), 32'(red));
    chk({tag, ".yel"}, 32'(car_yellow), 32'(yel));
    chk({tag, ".grn"}, 32'(car_green), 32'(grn));
    chk({tag, ".ap"},  32'(active_phase), 32'(ph));
    chk({tag, ".rem"}, 32'(remaining), 32'(rem));
  endtask

  task automatic deb_pulse();
    deb_tick = 1'b1;
    step();
    deb_tick = 1'b0;
    step();
  endtask

  // One full fixed-mode phase starting on its all-red entry cycle.
  task automatic run_fixed_phase(input int ph);
    logic [2:0] oh;
    logic [2:0] oth;
    oh  = 3'(1 << ph);
    oth = ~oh;
    for (int i = 0; i < 2; i++) begin
      chk_lamps($sformatf("fx%0d.ar%0d", ph, i), 3'b111, 3'b000, 3'b000, ph, 1 - i);
      chk($sformatf("fx%0d.ar%0d.pr", ph, i), 32'(ped_red), 32'h7);
      step();
    end
    for (int i = 0; i < 2; i++) begin
      chk_lamps($sformatf("fx%0d.ry%0d", ph, i), 3'b111, oh, 3'b000, ph, 1 - i);
      step();
    end
    for (int i = 0; i < 8; i++) begin
      chk_lamps($sformatf("fx%0d.g%0d", ph, i), oth, 3'b000, oh, ph, 7 - i);
      chk($sformatf("fx%0d.g%0d.pg", ph, i), 32'(ped_green), 32'(oh));
      chk($sformatf("fx%0d.g%0d.pr", ph, i), 32'(ped_red), 32'(oth));
      step();
    end
    for (int i = 0; i < 4; i++) begin
      chk_lamps($sformatf("fx%0d.gb%0d", ph, i), oth, 3'b000, (i % 2 == 1) ? oh : 3'b000, ph, 3 - i);
      step();
    end
    for (int i = 0; i < 3; i++) begin
      chk_lamps($sformatf("fx%0d.y%0d", ph, i), oth, oh, 3'b000, ph, 2 - i);
      step();
    end
  endtask

  // Hard stop in case the sequence ever stalls.
  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; enable = 1'b0; tick = 1'b0; deb_tick = 1'b0; actuated = 1'b0;
    car_req = '0; ped_req = '0; preempt = 1'b0; preempt_phase = '0;
    steps(2);

    // Reset state
    chk_lamps("rst", 3'b000, 3'b000, 3'b000, 0, 0);
    chk("rst.pg", 32'(ped_green), 32'h0);
    chk("rst.pr", 32'(ped_red), 32'h0);
    chk("rst.pl", 32'(ped_latched), 32'h0);

    // Fixed rotation 0 -> 1 -> 2 -> 0
    rst = 1'b0; enable = 1'b1; tick = 1'b1;
    step();
    run_fixed_phase(0);
    run_fixed_phase(1);
    run_fixed_phase(2);
    chk_lamps("fx.wrap", 3'b111, 3'b000, 3'b000, 0, 1);

    // Actuated: demand only on phase 2 ends green at minimum and skips phase 1
    rst = 1'b1; step();
    rst = 1'b0; actuated = 1'b1; step();
    steps(4);
    chk_lamps("act.g0", 3'b110, 3'b000, 3'b001, 0, 7);
    car_req = 3'b100;
    steps(3);
    chk_lamps("act.g3", 3'b110, 3'b000, 3'b001, 0, 4);
    step();
    chk_lamps("act.gb", 3'b110, 3'b000, 3'b000, 0, 3);
    steps(7);
    chk_lamps("act.skip", 3'b111, 3'b000, 3'b000, 2, 1);

    // Actuated rest in green, then demand releases it
    rst = 1'b1; car_req = '0; step();
    rst = 1'b0; step();
    steps(4);
    steps(10);
    chk_lamps("rest", 3'b110, 3'b000, 3'b001, 0, 0);
    car_req = 3'b010;
    step();
    chk_lamps("rest.exit", 3'b110, 3'b000, 3'b000, 0, 3);

    // Pedestrian debounce: short press rejected, full press latched, cleared at green
    rst = 1'b1; car_req = '0; actuated = 1'b0; tick = 1'b0; step();
    rst = 1'b0;
    ped_req = 3'b010; steps(3);
    deb_pulse(); deb_pulse();
    ped_req = 3'b000; steps(3);
    deb_pulse();
    chk("ped.short", 32'(ped_latched), 32'h0);
    ped_req = 3'b010; steps(3);
    deb_pulse(); deb_pulse();
    chk("ped.two", 32'(ped_latched), 32'h0);
    deb_tick = 1'b1; tick = 1'b1;
    step();
    deb_tick = 1'b0; ped_req = 3'b000;
    chk("ped.latch", 32'(ped_latched), 32'h2);
    chk("ped.tick", 32'(car_red), 32'h7);
    steps(22);
    chk("ped.hold", 32'(ped_latched), 32'h2);
    chk_lamps("ped.ry1", 3'b111, 3'b010, 3'b000, 1, 0);
    step();
    chk("ped.clr", 32'(ped_latched), 32'h0);
    chk_lamps("ped.g1", 3'b101, 3'b000, 3'b010, 1, 7);

    // Preemption toward phase 2 from phase 0 green
    rst = 1'b1; step();
    rst = 1'b0; step();
    steps(4);
    step();
    preempt = 1'b1; preempt_phase = 2'd2;
    step();
    chk_lamps("pre.y", 3'b110, 3'b001, 3'b000, 0, 2);
    steps(3);
    chk_lamps("pre.ar", 3'b111, 3'b000, 3'b000, 2, 1);
    steps(2);
    chk_lamps("pre.ry", 3'b111, 3'b100, 3'b000, 2, 1);
    steps(2);
    chk_lamps("pre.g2", 3'b011, 3'b000, 3'b100, 2, 7);
    steps(12);
    chk_lamps("pre.hold", 3'b011, 3'b000, 3'b100, 2, 0);
    preempt = 1'b0;
    step();
    chk_lamps("pre.rel", 3'b011, 3'b000, 3'b000, 2, 3);

    // Standby mid-green, flashing yellow, then reset mid-yellow
    rst = 1'b1; tick = 1'b0; step();
    rst = 1'b0;
    ped_req = 3'b100; steps(3);
    deb_pulse(); deb_pulse(); deb_pulse();
    ped_req = 3'b000;
    chk("en.pl", 32'(ped_latched), 32'h4);
    tick = 1'b1;
    steps(5);
    steps(2);
    chk_lamps("en.g", 3'b110, 3'b000, 3'b001, 0, 5);
    enable = 1'b0; tick = 1'b0;
    step();
    chk_lamps("en.idle", 3'b000, 3'b000, 3'b000, 0, 0);
    chk("en.pr", 32'(ped_red), 32'h0);
    chk("en.pl0", 32'(ped_latched), 32'h0);
    step();
    chk("en.y0", 32'(car_yellow), 32'h0);
    tick = 1'b1;
    step();
    chk("en.y1", 32'(car_yellow), 32'h7);
    step();
    chk("en.y2", 32'(car_yellow), 32'h0);
    step();
    chk("en.y3", 32'(car_yellow), 32'h7);
    enable = 1'b1;
    step();
    chk_lamps("re.ar", 3'b111, 3'b000, 3'b000, 0, 1);
    steps(16);
    chk_lamps("re.y", 3'b110, 3'b001, 3'b000, 0, 2);
    step();
    rst = 1'b1;
    step();
    chk_lamps("rst.mid", 3'b000, 3'b000, 3'b000, 0, 0);
    chk("rst.mid.pg", 32'(ped_green), 32'h0);
    chk("rst.mid.pr", 32'(ped_red), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/traffic_intersection_ctrl.md
TRAFFIC_INTERSECTION_CTRL -- requirements
Module: traffic_intersection_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: ports clk and rst.
REQ-002 The block SHALL have parameters (name, default, meaning), one per line:
  NUM_PHASES  2  signal phases, legal 2..4
  TW  8  timer width
  T_RED_YELLOW  10  red+yellow ticks
  T_MIN_GREEN  40  minimum green ticks
  T_GREEN  150  maximum green ticks
  T_GREEN_BLINK  40  blinking-green ticks
  T_YELLOW  30  yellow ticks
  T_ALL_RED  20  all-red clearance ticks
  BLINK_TICKS  5  ticks per blink half-period
  DEBOUNCE_TICKS  50  deb_tick samples for a pedestrian press
REQ-003 The block SHALL have these ports (name, direction, width, meaning), one per line; P = NUM_PHASES, PW = max(1,$clog2(P)):
  clk  in  1  system clock
  rst  in  1  synchronous active-high reset
  tick  in  1  1-cycle timing strobe (10 Hz)
  deb_tick  in  1  1-cycle debounce strobe (1 kHz)
  enable  in  1  0 = flashing-yellow standby
  actuated  in  1  1 = demand-driven phase selection, 0 = fixed rotation
  car_req  in  P  vehicle detector per phase, level
  ped_req  in  P  pedestrian button per phase, raw
  preempt  in  1  emergency preemption request, level
  preempt_phase  in  PW  phase to serve under preemption
  car_red, car_yellow, car_green  out  P each  vehicle lamps
  ped_red, ped_green  out  P each  pedestrian lamps
  ped_latched  out  P  debounced, latched pedestrian demand
  active_phase  out  PW  phase currently served
  remaining  out  TW  ticks left in current timed state

Function
REQ-004 Timed state machine states: IDLE, ALL_RED, RED_YELLOW, GREEN, GREEN_BLINK, YELLOW; transitions evaluated only in cycles with tick=1.
REQ-005 Each timed state SHALL last exactly its T_* ticks: a tick counter clears on entry and the state exits on the tick where counter == T_x-1.
REQ-006 remaining SHALL equal T_x-1-counter in timed states; in IDLE it SHALL be 0.
REQ-007 Sequence: IDLE -> ALL_RED (active_phase=0) -> RED_YELLOW -> GREEN -> GREEN_BLINK -> YELLOW -> ALL_RED (next phase) -> RED_YELLOW ...
REQ-008 GREEN exit: at T_GREEN; or at/after T_MIN_GREEN when any other phase has demand (car_req or ped_latched) in actuated mode, or preempt targets another phase.
REQ-009 Actuated mode, at T_GREEN with no demand on other phases: GREEN SHALL rest (counter saturates, remaining=0) until demand appears, then exit on the next tick.
REQ-010 Next phase on ALL_RED entry: fixed mode -> (active_phase+1) mod P; actuated -> first phase with demand searching round-robin from active_phase+1, else active_phase+1.
REQ-011 Preemption: preempt=1 with preempt_phase != active_phase in GREEN or GREEN_BLINK SHALL force YELLOW on the next tick; next phase SHALL be preempt_phase; while preempt=1 and served phase matches, GREEN SHALL hold indefinitely.
REQ-012 Lamps for active phase p: RED_YELLOW -> red+yellow; GREEN -> green; GREEN_BLINK -> green=blink; YELLOW -> yellow; other phases and ALL_RED -> red only.
REQ-013 Pedestrian lamps: ped_green[p] = 1 in GREEN, = blink in GREEN_BLINK, for active phase only; ped_red = ~ped_green outside IDLE.
REQ-014 IDLE: car_yellow = {P{blink}}, all other lamps 0.
REQ-015 blink SHALL toggle every BLINK_TICKS ticks in IDLE or GREEN_BLINK and be forced 0 (counter cleared) in all other states.
REQ-016 enable=0 SHALL force IDLE on the next clk edge regardless of tick and clear ped_latched; leaving IDLE requires enable=1 on a tick.
REQ-017 ped_latched[p] SHALL set after ped_req[p] is high for DEBOUNCE_TICKS consecutive deb_ticks; any low sample restarts the count.
REQ-018 ped_latched[p] SHALL clear on entry to GREEN of phase p; set and clear in the same cycle -> clear wins.
REQ-019 Simultaneous tick and deb_tick SHALL both be processed in that cycle.

Reset
REQ-020 rst=1 SHALL force IDLE, active_phase=0, all counters, blink and ped_latched to 0, remaining=0, all lamps 0 except car_yellow=blink=0; reset mid-sequence SHALL take effect on the next edge.

Structure
REQ-021 State encoding and default timing constants SHALL reside in shared package traffic_pkg.
REQ-022 Debounce-and-latch SHALL be sub-module ped_debounce, instantiated P times.

Verification (P=3, T_RED_YELLOW=2, T_MIN_GREEN=4, T_GREEN=8, T_GREEN_BLINK=4, T_YELLOW=3, T_ALL_RED=2, BLINK_TICKS=1, DEBOUNCE_TICKS=3, tick every cycle)
REQ-023 Fixed mode, enable=1 from reset -> phase 0 green for exactly 8 ticks, then 4 blink, 3 yellow, 2 all-red; active_phase 0->1->2->0.
REQ-024 Actuated, only car_req[2]=1 while phase 0 green -> GREEN exits after 4 ticks, phase 1 skipped, active_phase=2.
REQ-025 Actuated, no demand -> phase 0 rests in GREEN, remaining=0; car_req[1] raised -> GREEN_BLINK on next tick.
REQ-026 ped_req[1] high 2 deb_ticks then low -> no latch; high 3 deb_ticks -> ped_latched[1]=1, cleared on phase 1 GREEN entry.
REQ-027 preempt=1, preempt_phase=2 during phase 0 GREEN -> YELLOW next tick, then ALL_RED, RED_YELLOW, phase 2 GREEN held until preempt=0.
REQ-028 enable=0 mid-GREEN -> IDLE next edge, car_yellow toggling 3'b111/3'b000 each tick; rst mid-YELLOW -> all outputs 0 next edge.
